// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC, drives instruction memory and captures fetched words into a one-entry valid/ready output register
module fetch_controller #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    MEM_SIZE   = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_fault
);
    localparam logic [DATA_WIDTH-1:0] NOP   = DATA_WIDTH'(32'h0000_0013);
    localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE * 4);

    typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_instr_q;
    logic [ADDR_WIDTH-1:0]   out_pc_q;
    logic                    out_fault_q;
    logic                    slot_free;
    logic                    bad_pc;
    logic                    cap;

    // Capture qualification; the out-of-range compare is one bit wider so MEM_SIZE*4 cannot overflow
    always_comb begin
        slot_free = !out_valid_q || out_ready;
        bad_pc    = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= LIMIT);
        cap       = (state_q == RUN) && fetch_en && slot_free && !redirect_valid;
    end

    // Redirect beats capture, capture beats drain; a fault capture freezes the PC and parks the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= NOP;
            out_pc_q    <= '0;
            out_fault_q <= 1'b0;
        end else if (redirect_valid) begin
            state_q     <= RUN;
            pc_q        <= redirect_pc;
            out_valid_q <= 1'b0;
        end else if (cap && !bad_pc) begin
            out_instr_q <= imem_instr;
            out_pc_q    <= pc_q;
            out_fault_q <= 1'b0;
            out_valid_q <= 1'b1;
            pc_q        <= pc_q + ADDR_WIDTH'(4);
        end else if (cap) begin
            out_instr_q <= NOP;
            out_pc_q    <= pc_q;
            out_fault_q <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= FAULT;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign out_fault = out_fault_q;
endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences instruction fetch from the combinational, byte-addressable instruction memory. Owns the program counter, drives the memory address, and captures each fetched word with its PC into a one-entry output register. The output register has a valid/ready handshake toward decode. Handles redirects (branch/jump targets) with a flush, back-pressure, fetch gating, and misaligned or out-of-range fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
MEM_SIZE, 1024, instruction memory depth in 32-bit words; the legal fetch range is [0, MEM_SIZE*4).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
fetch_en  input  1  enables new fetches; low freezes the PC and blocks captures.
redirect_valid  input  1  one-cycle pulse: load PC from redirect_pc and flush the output register.
redirect_pc  input  ADDR_WIDTH  redirect target address.
imem_addr  output  ADDR_WIDTH  address to instruction memory; equals the PC register.
imem_instr  input  DATA_WIDTH  combinational read data from instruction memory.
out_valid  output  1  output register holds a fetched instruction.
out_ready  input  1  decode accepts the output this cycle.
out_instr  output  DATA_WIDTH  fetched instruction.
out_pc  output  ADDR_WIDTH  address of out_instr.
out_fault  output  1  out_instr is a fault marker, not a real instruction.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=RUN, out_valid=0, out_instr=32'h00000013, out_pc=0, out_fault=0.
  - Reset asserted mid-operation discards any held output immediately.
- imem_addr = pc, combinationally from the register. No other logic sits on this path.
- States:
  - RUN: normal fetching.
  - FAULT: fetching stopped after a fault capture.
- Terms:
  - slot_free = !out_valid || out_ready
  - bad_pc = (pc[1:0] != 0) || (pc >= MEM_SIZE*4)
  - cap = state==RUN && fetch_en && slot_free && !redirect_valid
- Priority per clock edge:
  1. redirect_valid=1:
     - pc <= redirect_pc, out_valid <= 0 (flush, even if out_ready=0), state <= RUN.
     - No capture this cycle. An output handed over in the same cycle (out_valid && out_ready) counts as consumed.
  2. cap with !bad_pc:
     - out_instr <= imem_instr, out_pc <= pc, out_fault <= 0, out_valid <= 1, pc <= pc+4.
  3. cap with bad_pc:
     - out_instr <= 32'h00000013, out_pc <= pc, out_fault <= 1, out_valid <= 1.
     - pc unchanged, state <= FAULT.
  4. Otherwise, if out_valid && out_ready: out_valid <= 0.
  5. Otherwise: hold all outputs.
- Latency: a capture is visible one cycle after the edge. With out_ready and fetch_en held high, throughput is one instruction per cycle.
- Back-pressure:
  - While out_valid && !out_ready, out_instr, out_pc and out_fault are stable.
  - PC does not advance during back-pressure.
- fetch_en low: no capture and PC frozen. A pending output may still drain via out_ready.
- FAULT state:
  - No captures. The fault entry drains normally; afterwards out_valid stays 0.
  - Leaves only via redirect (to RUN) or reset.
- Misaligned redirect_pc is accepted into PC. The fault is raised at the next capture attempt.
- PC increment is modulo 2^32. Wrap past 32'hFFFFFFFC is unreachable without a fault, because that address is out of range.

Test Plan:
1. Streaming: imem holds 0x00a00093@0x0, 0x01400113@0x4, 0x002081b3@0x8; fetch_en=1, out_ready=1 from reset release -> outputs (pc,instr) = (0x0,0x00a00093), (0x4,0x01400113), (0x8,0x002081b3) on consecutive cycles, out_fault=0.
2. Back-pressure: out_ready=0 for 3 cycles while out_pc=0x4 -> out_pc/out_instr stay 0x4/0x01400113 and imem_addr stays 0x8. Release -> next output is pc 0x8 the following cycle.
3. Redirect: redirect_valid pulse with redirect_pc=0x14 while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, then out_pc=0x14. The previously held entry is never accepted.
4. Misaligned fault: redirect_pc=0x6 -> one output with out_fault=1, out_pc=0x6, out_instr=0x00000013. Then out_valid stays 0. A later redirect to 0x0 resumes fetching at 0x0.
5. Range fault (MEM_SIZE=4): stream from 0x0 -> four normal outputs (0x0 to 0xC), then a fault output at 0x10, then no further output.
6. Reset mid-stream: rst_n low asynchronously between edges -> out_valid=0 and imem_addr=RESET_PC immediately. After release, the stream restarts at RESET_PC.
